// File: rtl/hamming_enc_scheduler.sv
// Round-robin scheduler sharing one external 26->32 bit encoder between two requesters.
// Grants a word, holds it on enc_data for ENC_WAIT cycles, captures and parity-checks the codeword.
module hamming_enc_scheduler #(
  parameter int unsigned ENC_WAIT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [25:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [25:0]      b_data,
  output logic             b_ready,
  output logic [25:0]      enc_data,
  input  logic [31:0]      enc_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_code,
  output logic             out_src,
  output logic             out_perr,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant_a;
  logic             grant_b;
  logic             capture;
  logic             retire;
  logic             rr_b;
  logic             src;
  logic [CNT_W-1:0] cnt;
  logic             code_par;

  assign code_par = ^enc_code;
  assign a_ready  = grant_a;
  assign b_ready  = grant_b;

  // Next-state and grant decode; grants exist only in IDLE.
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (a_valid && (!b_valid || !rr_b)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; busy tracks the registered state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Request capture, settle counter and round-robin pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enc_data <= '0;
      src      <= 1'b0;
      rr_b     <= 1'b0;
      cnt      <= '0;
    end else if (grant_a || grant_b) begin
      enc_data <= grant_a ? a_data : b_data;
      src      <= grant_b;
      rr_b     <= grant_a;
      cnt      <= CNT_W'(ENC_WAIT - 1);
    end else if (state == ST_WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Output holding registers and saturating parity-error counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_src   <= 1'b0;
      out_perr  <= 1'b0;
      err_count <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_code  <= enc_code;
      out_src   <= src;
      out_perr  <= code_par;
      if (code_par && err_count != '1) begin
        err_count <= err_count + ERR_W'(1);
      end
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_enc_scheduler.sv
// Self-checking bench for hamming_enc_scheduler: scoreboard of expected codewords plus
// per-scenario checks of latency, arbitration, parity counting, back-pressure and reset.
module tb_hamming_enc_scheduler;

  typedef struct packed {
    logic        src;
    logic [31:0] code;
    logic        perr;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [25:0] a_data, b_data, enc_data;
  logic [31:0] enc_code, out_code;
  logic        out_valid, out_ready, out_src, out_perr, busy;
  logic [7:0]  err_count;
  logic        flip;

  logic        a5_valid, a5_ready, b5_valid, b5_ready;
  logic [25:0] a5_data, b5_data, enc5_data;
  logic [31:0] enc5_code, out5_code;
  logic        out5_valid, out5_ready, out5_src, out5_perr, busy5;
  logic [7:0]  err5_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Stand-in encoder: any mapping with even overall parity; flip corrupts bit 31.
  function automatic logic [31:0] enc_model(input logic [25:0] d);
    logic [30:0] low;
    low = 31'(d) * 31'd7;
    return {^low, low};
  endfunction

  assign enc_code  = enc_model(enc_data) ^ {flip, 31'b0};
  assign enc5_code = enc_model(enc5_data);

  hamming_enc_scheduler #(.ENC_WAIT(2), .ERR_W(8)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .enc_data(enc_data), .enc_code(enc_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_src(out_src), .out_perr(out_perr), .err_count(err_count), .busy(busy)
  );

  hamming_enc_scheduler #(.ENC_WAIT(5), .ERR_W(8)) dut5 (
    .clock(clock), .reset(reset),
    .a_valid(a5_valid), .a_data(a5_data), .a_ready(a5_ready),
    .b_valid(b5_valid), .b_data(b5_data), .b_ready(b5_ready),
    .enc_data(enc5_data), .enc_code(enc5_code),
    .out_valid(out5_valid), .out_ready(out5_ready), .out_code(out5_code),
    .out_src(out5_src), .out_perr(out5_perr), .err_count(err5_count), .busy(busy5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: push on observed grant, pop and compare on observed retirement.
  always @(negedge clock) begin : mon
    exp_t e;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected: got out_code %h with no word expected", out_code);
        end else begin
          e = exp_q.pop_front();
          if (out_code !== e.code || out_src !== e.src || out_perr !== e.perr) begin
            errors = errors + 1;
            $display("FAIL sb_word: got code %h src %b perr %b expected code %h src %b perr %b",
                     out_code, out_src, out_perr, e.code, e.src, e.perr);
          end
        end
      end
      if (a_valid && a_ready) exp_q.push_back({1'b0, enc_model(a_data) ^ {flip, 31'b0}, flip});
      if (b_valid && b_ready) exp_q.push_back({1'b1, enc_model(b_data) ^ {flip, 31'b0}, flip});
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clock);
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_idle_timeout: got busy %b expected 0 within 50 cycles", tag, busy);
    end
  endtask

  task automatic send_word(input logic use_b, input logic [25:0] d);
    int n = 0;
    @(posedge clock); #2;
    if (use_b) begin b_valid = 1'b1; b_data = d; end
    else       begin a_valid = 1'b1; a_data = d; end
    @(negedge clock);
    while (!(use_b ? b_ready : a_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!(use_b ? b_ready : a_ready)) begin
      errors++;
      $display("FAIL grant_timeout: got ready 0 expected 1 within 50 cycles");
    end
    @(posedge clock); #2;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2;
    reset = 1'b0;
    @(negedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_code !== 32'h0) begin errors++; $display("FAIL rst_out_code: got %h expected 0", out_code); end
    checks++; if (enc_data !== 26'h0) begin errors++; $display("FAIL rst_enc_data: got %h expected 0", enc_data); end
    checks++; if ({out_src, out_perr, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {out_src, out_perr, busy}); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL rst_err_count: got %h expected 0", err_count); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b expected 00", {a_ready, b_ready}); end
    @(posedge clock); #2;
    reset = 1'b1;
  endtask

  task automatic test_single_a();
    @(posedge clock); #2;
    a_valid = 1'b1; a_data = 26'h0000001;
    @(negedge clock);
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_grant: got %b expected 10", {a_ready, b_ready}); end
    @(posedge clock); #2;
    a_valid = 1'b0;
    @(negedge clock);
    checks++; if ({a_ready, busy, out_valid} !== 3'b010) begin errors++; $display("FAIL single_after_accept: got %b expected 010", {a_ready, busy, out_valid}); end
    checks++; if (enc_data !== 26'h0000001) begin errors++; $display("FAIL single_enc_data: got %h expected 0000001", enc_data); end
    @(posedge clock); #2;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    @(posedge clock); #2;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", out_valid); end
    checks++; if (out_code !== 32'h80000007) begin errors++; $display("FAIL single_code: got %h expected 80000007", out_code); end
    checks++; if ({out_src, out_perr} !== 2'b00) begin errors++; $display("FAIL single_src_perr: got %b expected 00", {out_src, out_perr}); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL single_err_count: got %h expected 0", err_count); end
    wait_idle("single");
  endtask

  task automatic serve_pair(input int idx);
    logic order [2];
    int   got = 0;
    int   n = 0;
    logic drop_a, drop_b;
    order[0] = 1'b1;
    order[1] = 1'b0;
    @(posedge clock); #2;
    a_valid = 1'b1; a_data = 26'h0000001;
    b_valid = 1'b1; b_data = 26'h2000000;
    while (got < 2 && n < 100) begin
      @(negedge clock);
      drop_a = 1'b0;
      drop_b = 1'b0;
      if (a_ready) begin order[got] = 1'b0; got++; drop_a = 1'b1; end
      if (b_ready && got < 2) begin order[got] = 1'b1; got++; drop_b = 1'b1; end
      @(posedge clock); #2;
      if (drop_a) a_valid = 1'b0;
      if (drop_b) b_valid = 1'b0;
      n++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++; if (got != 2) begin errors++; $display("FAIL rr_pair%0d_timeout: got %0d grants expected 2", idx, got); end
    checks++; if (order[0] !== 1'b0) begin errors++; $display("FAIL rr_pair%0d_first: got src %b expected 0", idx, order[0]); end
    checks++; if (order[1] !== 1'b1) begin errors++; $display("FAIL rr_pair%0d_second: got src %b expected 1", idx, order[1]); end
    wait_idle("rr");
  endtask

  task automatic test_round_robin();
    pulse_reset();
    serve_pair(0);
    serve_pair(1);
  endtask

  task automatic test_parity_saturation();
    flip = 1'b1;
    send_word(1'b0, 26'h0000001);
    wait_idle("perr");
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL perr_count1: got %h expected 01", err_count); end
    for (int i = 1; i < 255; i++) begin
      send_word(i[0], 26'(i));
      wait_idle("perr");
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL perr_count255: got %h expected ff", err_count); end
    for (int i = 0; i < 5; i++) begin
      send_word(1'b0, 26'(i + 300));
      wait_idle("perr");
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL perr_saturate: got %h expected ff", err_count); end
    flip = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_code;
    int n = 0;
    exp_code = enc_model(26'h0ABCDEF);
    out_ready = 1'b0;
    send_word(1'b0, 26'h0ABCDEF);
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", out_valid); end
    @(posedge clock); #2;
    b_valid = 1'b1; b_data = 26'h3000001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp_code || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid %b code %h b_ready %b expected 1 %h 0", i, out_valid, out_code, b_ready, exp_code);
      end
      @(posedge clock); #2;
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL bp_retire_cycle: got b_ready %b expected 0", b_ready); end
    @(posedge clock); #2;
    @(negedge clock);
    checks++; if ({b_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_after_retire: got %b expected 10", {b_ready, out_valid}); end
    @(posedge clock); #2;
    b_valid = 1'b0;
    wait_idle("bp");
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    int   n = 0;
    send_word(1'b0, 26'h1234567);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", busy); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL rmid_async_flags: got %b expected 00", {out_valid, busy}); end
    checks++; if (enc_data !== 26'h0 || err_count !== 8'h0) begin errors++; $display("FAIL rmid_async_regs: got %h %h expected 0 0", enc_data, err_count); end
    @(negedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_ghost_output: got out_valid 1 expected 0"); end
    @(posedge clock); #2;
    a_valid = 1'b1; a_data = 26'h0000055;
    b_valid = 1'b1; b_data = 26'h00000AA;
    @(negedge clock);
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL rmid_first_grant: got %b expected 10", {a_ready, b_ready}); end
    @(posedge clock); #2;
    a_valid = 1'b0;
    @(negedge clock);
    while (!b_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rmid_b_timeout: got b_ready %b expected 1", b_ready); end
    @(posedge clock); #2;
    b_valid = 1'b0;
    wait_idle("rmid");
  endtask

  task automatic test_enc_wait5();
    logic [25:0] d;
    d = 26'h1555555;
    @(posedge clock); #2;
    a5_valid = 1'b1; a5_data = d;
    @(negedge clock);
    checks++; if (a5_ready !== 1'b1) begin errors++; $display("FAIL w5_grant: got %b expected 1", a5_ready); end
    @(posedge clock); #2;
    a5_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock); #2;
      @(negedge clock);
      checks++;
      if (out5_valid !== (i == 5) || enc5_data !== d) begin
        errors++;
        $display("FAIL w5_edge%0d: got valid %b enc_data %h expected %b %h", i, out5_valid, enc5_data, (i == 5), d);
      end
    end
    checks++;
    if (out5_code !== enc_model(d) || out5_src !== 1'b0 || out5_perr !== 1'b0) begin
      errors++;
      $display("FAIL w5_word: got %h %b %b expected %h 0 0", out5_code, out5_src, out5_perr, enc_model(d));
    end
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    out_ready = 1'b1; flip = 1'b0;
    a5_valid = 1'b0; b5_valid = 1'b0; a5_data = '0; b5_data = '0; out5_ready = 1'b1;
    test_reset();
    test_single_a();
    test_round_robin();
    test_parity_saturation();
    test_backpressure();
    test_reset_mid();
    test_enc_wait5();
    repeat (4) @(negedge clock);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending words expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
